// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial I/O unit: mode codes, default modulus
// and controller state encoding.
package poly_pkg;

  localparam logic [1:0] M_NTT     = 2'd0;
  localparam logic [1:0] M_INTT    = 2'd1;
  localparam logic [1:0] M_DATAIN  = 2'd2;
  localparam logic [1:0] M_DATAOUT = 2'd3;

  localparam int Q_DEFAULT = 3329;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/poly_io_unit_skid.sv
// Two-entry output buffer between the RAM read path and the unload stream.
// Head word is held in a register, so out_data cannot move while stalled.
module poly_skid_buf #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  always_comb begin
    pop      = out_ready && (count_q != 2'd0);
    push     = in_valid && (count_q != 2'd2);
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    if (push) begin
      if (wr_ptr_q) mem1_d = in_data;
      else          mem0_d = in_data;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = rd_ptr_q ? mem1_q : mem0_q;
  assign count     = count_q;

endmodule

// File: rtl/poly_io_unit.sv
// Polynomial load/unload controller: streams words into a coefficient RAM with
// modular range reduction, and streams them back out through a skid buffer.
//
// state   | meaning
// S_IDLE  | waiting for run with a DATAIN/DATAOUT mode
// S_LOAD  | accepting in-stream beats, one RAM write per beat
// S_STORE | issuing RAM reads and draining them to the out-stream
// S_FIN   | one-cycle done pulse, then back to idle
module poly_io_unit
  import poly_pkg::*;
#(
  parameter  int WID   = 12,
  parameter  int LANES = 4,
  parameter  int DEPTH = 32,
  parameter  int Q     = Q_DEFAULT,
  localparam int W     = WID * LANES,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          run,
  output logic          busy,
  output logic          done,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wr,
  output logic [W-1:0]  ram_wdata,
  input  logic [W-1:0]  ram_rdata,
  output logic          err_range
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [WID:0]  QW   = (WID + 1)'(Q);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] out_cnt_q, out_cnt_d;
  logic          rd_done_q, rd_done_d;
  logic          inflight_q, inflight_d;
  logic          err_q, err_d;

  logic [W-1:0]  red_data;
  logic          any_over;
  logic [1:0]    buf_count;
  logic [2:0]    occ;
  logic          push, pop, issue;

  always_comb begin
    red_data = '0;
    any_over = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      logic [WID-1:0] lane;
      lane = in_data[l*WID +: WID];
      if ({1'b0, lane} >= QW) begin
        red_data[l*WID +: WID] = lane - QW[WID-1:0];
        any_over = 1'b1;
      end else begin
        red_data[l*WID +: WID] = lane;
      end
    end
  end

  // Occupancy the buffer will have next cycle if nothing new is issued;
  // a read is only allowed while that leaves room for its data.
  assign pop = out_valid && out_ready;
  assign occ = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_cnt_d  = out_cnt_q;
    rd_done_d  = rd_done_q;
    inflight_d = 1'b0;
    err_d      = err_q;
    in_ready   = 1'b0;
    ram_wr     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    issue      = 1'b0;
    push       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run && (mode == M_DATAIN || mode == M_DATAOUT)) begin
          cnt_d     = '0;
          out_cnt_d = '0;
          rd_done_d = 1'b0;
          err_d     = 1'b0;
          state_d   = (mode == M_DATAIN) ? S_LOAD : S_STORE;
        end
      end
      S_LOAD: begin
        // Gated by rst so a beat coinciding with reset never reaches the RAM.
        in_ready = rst;
        ram_addr = cnt_q;
        if (in_valid && rst) begin
          ram_wr    = 1'b1;
          ram_wdata = red_data;
          if (any_over) err_d = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_STORE: begin
        push     = inflight_q;
        ram_addr = cnt_q;
        issue    = !rd_done_q && (occ <= 3'd1);
        if (issue) begin
          inflight_d = 1'b1;
          if (cnt_q == LAST) rd_done_d = 1'b1;
          else               cnt_d     = cnt_q + 1'b1;
        end
        if (pop) begin
          if (out_cnt_q == LAST) state_d   = S_FIN;
          else                   out_cnt_d = out_cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      out_cnt_q  <= '0;
      rd_done_q  <= 1'b0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_cnt_q  <= out_cnt_d;
      rd_done_q  <= rd_done_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  poly_skid_buf #(.W(W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (push),
    .in_data  (ram_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (buf_count)
  );

  assign busy      = (state_q != S_IDLE);
  assign err_range = err_q;

endmodule

// File: tb/tb_poly_io_unit.sv
// Directed bench for poly_io_unit with a 1-cycle-latency RAM model.
module tb_poly_io_unit;
  import poly_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        run;
  logic        busy, done;
  logic [47:0] in_data;
  logic        in_valid, in_ready;
  logic [47:0] out_data;
  logic        out_valid, out_ready;
  logic [4:0]  ram_addr;
  logic        ram_wr;
  logic [47:0] ram_wdata, ram_rdata;
  logic        err_range;

  logic [47:0] mem [32];
  logic [47:0] exp_mem [32];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  poly_io_unit dut (
    .clk(clk), .rst(rst), .mode(mode), .run(run), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .err_range(err_range)
  );

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_in_ready"},  in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_ram_wr"},    ram_wr, 0);
    chk({tag, "_err"},       err_range, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_ram_addr"},  ram_addr, 0);
    chk({tag, "_wdata"},     ram_wdata, 0);
  endtask

  // Loads 32 words: word 0 is w0 (stored as e0), word k>0 is k in every lane.
  task automatic do_load(input logic [47:0] w0, input logic [47:0] e0, input logic exp_err);
    logic [47:0] e;
    mode = M_DATAIN; run = 1'b1;
    tick;
    run = 1'b0;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_data  = (k == 0) ? w0 : {4{12'(k)}};
      e        = (k == 0) ? e0 : {4{12'(k)}};
      if (k == 5) begin run = 1'b1; mode = M_DATAOUT; end
      else run = 1'b0;
      mid;
      chk("ld_in_ready", in_ready, 1);
      chk("ld_ram_wr", ram_wr, 1);
      chk("ld_ram_addr", ram_addr, 64'(k));
      chk("ld_wdata", ram_wdata, e);
      chk("ld_err", err_range, (k == 0) ? 1'b0 : exp_err);
      exp_mem[k] = e;
      tick;
    end
    in_valid = 1'b0; run = 1'b0;
    mid;
    chk("ld_done", done, 1);
    chk("ld_in_ready_off", in_ready, 0);
    chk("ld_ram_wr_off", ram_wr, 0);
    tick;
    mid;
    chk("ld_done_once", done, 0);
    chk("ld_idle", busy, 0);
    chk("ld_err_hold", err_range, exp_err);
    tick;
    for (int k = 0; k < 32; k++) chk("ld_mem", mem[k], exp_mem[k]);
  endtask

  // pat 0: out_ready held high; 1: toggling; 2: random.
  task automatic do_unload(input int pat);
    logic        stalled;
    logic [47:0] prev;
    int          idx;
    logic        seen;
    mode = M_DATAOUT; run = 1'b1; out_ready = 1'b1;
    tick;
    run = 1'b0;
    if (pat == 0) begin
      mid;
      chk("ul_lat1", out_valid, 0);
      chk("ul_err_clr", err_range, 0);
      chk("ul_busy", busy, 1);
      tick;
      mid;
      chk("ul_lat2", out_valid, 0);
      tick;
      for (int k = 0; k < 32; k++) begin
        mid;
        chk("ul_valid", out_valid, 1);
        chk("ul_data", out_data, exp_mem[k]);
        chk("ul_no_wr", ram_wr, 0);
        tick;
      end
      mid;
      chk("ul_done", done, 1);
      chk("ul_valid_off", out_valid, 0);
      tick;
    end else begin
      stalled = 1'b0; prev = '0; idx = 0; seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
        if (pat == 1) out_ready = c[0];
        else          out_ready = 1'($urandom_range(0, 1));
        mid;
        if (done) seen = 1'b1;
        else if (out_valid) begin
          if (stalled) chk("bp_stable", out_data, prev);
          if (out_ready) begin
            if (idx < 32) chk("bp_data", out_data, exp_mem[idx]);
            else          chk("bp_extra", 64'(idx), 31);
            idx++;
          end
        end
        stalled = out_valid && !out_ready;
        prev    = out_data;
        tick;
      end
      chk("bp_count", 64'(idx), 32);
      chk("bp_done_seen", seen, 1);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; mode = M_NTT;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick;
    mid;
    chk_zero("reset");
    tick;
    rst = 1'b1;

    // Ignored run codes in idle.
    run = 1'b1; mode = M_NTT;
    tick;
    mode = M_INTT;
    tick;
    run = 1'b0;
    mid;
    chk("ign_busy", busy, 0);
    chk("ign_in_ready", in_ready, 0);
    chk("ign_done_cnt", 64'(done_cnt), 0);
    tick;

    do_load({4{12'd0}}, {4{12'd0}}, 1'b0);
    chk("dc_load1", 64'(done_cnt), 1);

    do_load({12'd3329, 12'd3328, 12'd4095, 12'd0},
            {12'd0,    12'd3328, 12'd766,  12'd0}, 1'b1);
    chk("dc_load2", 64'(done_cnt), 2);

    do_unload(0);
    chk("dc_unload", 64'(done_cnt), 3);
    do_unload(1);
    chk("dc_toggle", 64'(done_cnt), 4);
    do_unload(2);
    chk("dc_random", 64'(done_cnt), 5);

    // Abort a load with reset on word 10.
    mode = M_DATAIN; run = 1'b1;
    tick;
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = {4{12'h123}};
      exp_mem[k] = {4{12'h123}};
      tick;
    end
    in_data = {4{12'h456}};
    rst = 1'b0;
    mid;
    chk("ab_no_wr", ram_wr, 0);
    tick;
    rst = 1'b1; in_valid = 1'b0;
    mid;
    chk_zero("abort");
    tick;
    chk("ab_mem9", mem[9], {4{12'h123}});
    chk("ab_mem10", mem[10], exp_mem[10]);
    repeat (3) tick;
    chk("ab_no_done", 64'(done_cnt), 5);

    do_load({4{12'd0}}, {4{12'd0}}, 1'b0);
    chk("dc_reload", 64'(done_cnt), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
